// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline controller: FSM states and stage indices.
package pipeline_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_MC_WAIT = 1'b1
   } state_e;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

endpackage

// File: rtl/pipeline_ctrl_mc_if.sv
// Event inputs, pipeline control outputs and counters of the pipeline controller.
interface pipeline_ctrl_mc_if
   import pipeline_ctrl_pkg::*;
#(
   parameter int NSTAGES = STG_WB + 1,
   parameter int CNT_W   = 16
);
   logic                load_use_hazard;
   logic                redirect_valid;
   logic                mc_start;
   logic                mc_done;
   logic                mem_wait;
   logic                cnt_clr;
   logic                pc_write;
   logic [NSTAGES-2:0]  preg_write;
   logic [NSTAGES-2:0]  preg_flush;
   logic                mc_busy;
   logic                mc_timeout;
   logic [CNT_W-1:0]    stall_cnt;
   logic [CNT_W-1:0]    flush_cnt;

   modport master (
      output load_use_hazard, redirect_valid, mc_start, mc_done, mem_wait, cnt_clr,
      input  pc_write, preg_write, preg_flush, mc_busy, mc_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  load_use_hazard, redirect_valid, mc_start, mc_done, mem_wait, cnt_clr,
      output pc_write, preg_write, preg_flush, mc_busy, mc_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_ctrl_mc.sv
// Pipeline controller: PC/pipeline-register enables, multi-cycle-unit wait FSM
// with timeout, memory-wait freeze and stall/flush performance counters.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_RUN     | normal issue; mc_start without mc_done enters the wait
//   ST_MC_WAIT | multi-cycle op outstanding; front end held until mc_done
module pipeline_ctrl_mc
   import pipeline_ctrl_pkg::*;
#(
   parameter int NSTAGES       = 5,
   parameter int HAZ_STAGE     = STG_ID,
   parameter int RESOLVE_STAGE = STG_EX,
   parameter int MC_STAGE      = STG_EX,
   parameter int MC_TIMEOUT    = 64,
   parameter int CNT_W         = 16
) (
   input  logic               clk,
   input  logic               rst,
   pipeline_ctrl_mc_if.slave  bus
);
   localparam int NREG   = NSTAGES - 1;
   localparam int TMR_W  = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam bit TMO_EN = (MC_TIMEOUT != 0);
   // Down-counter holds remaining wait cycles; zero is the terminal count.
   localparam logic [TMR_W-1:0] TMR_LOAD = (MC_TIMEOUT > 0) ? TMR_W'(MC_TIMEOUT - 1) : '0;

   state_e            state_q, state_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              tmo_q, tmo_d;
   logic              mc_stall;
   logic              pc_write;
   logic [NREG-1:0]   preg_write, preg_flush;
   logic              stall_inc, flush_inc;

   always_comb begin
      mc_stall   = !bus.mc_done && ((state_q == ST_MC_WAIT) || bus.mc_start);
      pc_write   = 1'b1;
      preg_write = '1;
      preg_flush = '0;
      flush_inc  = 1'b0;
      if (rst) begin
         pc_write   = 1'b0;
         preg_write = '0;
         preg_flush = '1;
      end else if (bus.mem_wait) begin
         pc_write   = 1'b0;
         preg_write = '0;
      end else if (mc_stall) begin
         pc_write = 1'b0;
         for (int k = 0; k < NREG; k++)
            if (k < MC_STAGE) preg_write[k] = 1'b0;
         preg_flush[MC_STAGE] = 1'b1;
      end else if (bus.redirect_valid && (state_q == ST_RUN)) begin
         // Redirect outranks load-use: the stalled instruction is wrong-path.
         for (int k = 0; k < NREG; k++)
            if (k < RESOLVE_STAGE) preg_flush[k] = 1'b1;
         flush_inc = 1'b1;
      end else if (bus.load_use_hazard) begin
         pc_write = 1'b0;
         for (int k = 0; k < NREG; k++)
            if (k < HAZ_STAGE) preg_write[k] = 1'b0;
         preg_flush[HAZ_STAGE] = 1'b1;
      end
      stall_inc = !rst && !pc_write;
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_RUN: begin
            if (bus.mc_start && !bus.mc_done) begin
               state_d = ST_MC_WAIT;
               tmr_d   = TMR_LOAD;
            end
         end
         ST_MC_WAIT: begin
            if (bus.mc_done) begin
               state_d = ST_RUN;
            end else if (TMO_EN && (tmr_q == '0)) begin
               state_d = ST_RUN;
               tmo_d   = 1'b1;
            end else if (tmr_q != '0) begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         tmr_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         tmo_q   <= tmo_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (bus.cnt_clr),
      .inc (stall_inc),
      .cnt (bus.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .clr (bus.cnt_clr),
      .inc (flush_inc),
      .cnt (bus.flush_cnt)
   );

   assign bus.pc_write   = pc_write;
   assign bus.preg_write = preg_write;
   assign bus.preg_flush = preg_flush;
   assign bus.mc_busy    = (state_q == ST_MC_WAIT);
   assign bus.mc_timeout = tmo_q;
endmodule

// File: tb/tb_pipeline_ctrl_mc.sv
// Bench for pipeline_ctrl_mc: directed scenarios plus random traffic against a
// cycle-level behavioural model of the controller rules.
module tb_pipeline_ctrl_mc;
   localparam int NS   = 5;
   localparam int NR   = NS - 1;
   localparam int HAZ  = 1;
   localparam int RES  = 2;
   localparam int MCS  = 2;
   localparam int TMO  = 64;
   localparam int CW   = 16;
   localparam int ALL  = (1 << NR) - 1;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipeline_ctrl_mc_if #(.NSTAGES(NS), .CNT_W(CW)) bus ();

   pipeline_ctrl_mc #(
      .NSTAGES(NS), .HAZ_STAGE(HAZ), .RESOLVE_STAGE(RES),
      .MC_STAGE(MCS), .MC_TIMEOUT(TMO), .CNT_W(CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_chk = 0;
   int n_err = 0;

   bit m_busy = 1'b0;
   bit m_tmo  = 1'b0;
   int m_waited = 0;
   int m_stall  = 0;
   int m_flush  = 0;
   int e_pc, e_wr, e_fl, e_finc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_outputs();
      bit stall_mc;
      stall_mc = !bus.mc_done && (m_busy || bus.mc_start);
      e_pc = 1; e_wr = ALL; e_fl = 0; e_finc = 0;
      if (rst) begin
         e_pc = 0; e_wr = 0; e_fl = ALL;
      end else if (bus.mem_wait) begin
         e_pc = 0; e_wr = 0;
      end else if (stall_mc) begin
         e_pc = 0; e_wr = ALL - ((1 << MCS) - 1); e_fl = 1 << MCS;
      end else if (bus.redirect_valid && !m_busy) begin
         e_fl = (1 << RES) - 1; e_finc = 1;
      end else if (bus.load_use_hazard) begin
         e_pc = 0; e_wr = ALL - ((1 << HAZ) - 1); e_fl = 1 << HAZ;
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_busy = 0; m_tmo = 0; m_waited = 0; m_stall = 0; m_flush = 0;
         return;
      end
      if (bus.cnt_clr) begin
         m_stall = 0; m_flush = 0;
      end else begin
         if (e_pc == 0 && m_stall < MAXC) m_stall++;
         if (e_finc == 1 && m_flush < MAXC) m_flush++;
      end
      if (!m_busy) begin
         if (bus.mc_start && !bus.mc_done) begin
            m_busy = 1; m_waited = 1;
         end
      end else if (bus.mc_done) begin
         m_busy = 0;
      end else if (m_waited == TMO) begin
         m_busy = 0; m_tmo = 1;
      end else begin
         m_waited++;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_outputs();
      chk("pc_write",   bus.pc_write,   e_pc);
      chk("preg_write", bus.preg_write, e_wr);
      chk("preg_flush", bus.preg_flush, e_fl);
      chk("mc_busy",    bus.mc_busy,    m_busy);
      chk("mc_timeout", bus.mc_timeout, m_tmo);
      chk("stall_cnt",  bus.stall_cnt,  m_stall);
      chk("flush_cnt",  bus.flush_cnt,  m_flush);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_in(input bit r, input bit lu, input bit rd, input bit st,
                         input bit dn, input bit mw, input bit cl);
      rst                 = r;
      bus.load_use_hazard = lu;
      bus.redirect_valid  = rd;
      bus.mc_start        = st;
      bus.mc_done         = dn;
      bus.mem_wait        = mw;
      bus.cnt_clr         = cl;
   endtask

   initial begin
      // reset with every input high, then release to idle
      set_in(1, 1, 1, 1, 1, 1, 1);
      @(posedge clk);
      #1;
      repeat (3) cycle();
      chk("rst_stall_cnt", bus.stall_cnt, 0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      cycle();

      // load-use alone
      set_in(0, 1, 0, 0, 0, 0, 0);
      cycle();
      chk("lu_stall_cnt", bus.stall_cnt, 1);

      // redirect together with load-use: redirect wins
      set_in(0, 1, 1, 0, 0, 0, 0);
      cycle();
      chk("redir_flush_cnt", bus.flush_cnt, 1);
      chk("redir_stall_cnt", bus.stall_cnt, 1);

      // multi-cycle op done after 4 wait cycles, redirect mid-wait ignored
      set_in(1, 0, 0, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 1, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 1, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      repeat (2) cycle();
      chk("mc_busy_before_done", bus.mc_busy, 1);
      set_in(0, 0, 0, 0, 1, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      chk("mc_stall_cnt", bus.stall_cnt, 5);
      chk("mc_flush_cnt", bus.flush_cnt, 0);
      chk("mc_busy_after", bus.mc_busy, 0);

      // single-cycle op: no stall, stays in RUN
      set_in(0, 0, 0, 1, 1, 0, 0);
      cycle();
      chk("op1_busy", bus.mc_busy, 0);
      chk("op1_stall_cnt", bus.stall_cnt, 5);

      // timeout
      set_in(1, 0, 0, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 1, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      repeat (63) cycle();
      chk("tmo_not_yet", bus.mc_timeout, 0);
      cycle();
      chk("tmo_set", bus.mc_timeout, 1);
      chk("tmo_busy", bus.mc_busy, 0);
      repeat (5) cycle();
      chk("tmo_sticky", bus.mc_timeout, 1);
      set_in(1, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("tmo_cleared", bus.mc_timeout, 0);

      // reset mid-wait, late mc_done ignored
      set_in(0, 0, 0, 1, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      repeat (3) cycle();
      set_in(1, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("rst_mid_busy", bus.mc_busy, 0);
      set_in(0, 0, 0, 0, 1, 0, 0);
      cycle();
      chk("late_done_busy", bus.mc_busy, 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         set_in($urandom_range(0, 99) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 11) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 39) == 0);
         cycle();
      end

      // stall counter saturation, then clear beating a stall
      set_in(1, 0, 0, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 1, 0);
      repeat (16'hFFFE) cycle();
      chk("sat_fffe", bus.stall_cnt, 16'hFFFE);
      repeat (3) cycle();
      chk("sat_ffff", bus.stall_cnt, 16'hFFFF);
      set_in(0, 0, 0, 0, 0, 1, 1);
      cycle();
      chk("clr_beats_inc", bus.stall_cnt, 0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      cycle();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/pipeline_ctrl_mc.md
Name: pipeline_ctrl_mc

Overview:
Parametrised pipeline controller for an N-stage in-order RISC-V core. Adds a multi-cycle-unit wait FSM with timeout, a global memory-wait freeze and saturating stall/flush performance counters. Sits beside the hazard unit. Drives PC write enable plus per-pipeline-register write/flush vectors. Pipeline register k sits between stage k and stage k+1 (stage 0 = IF).

Parameters:
NSTAGES, 5, pipeline stage count; range 4..8.
HAZ_STAGE, 1, stage where load-use is detected (ID).
RESOLVE_STAGE, 2, stage where branch/jal/jalr resolve (EX); must satisfy HAZ_STAGE < RESOLVE_STAGE <= NSTAGES-2.
MC_STAGE, 2, stage hosting the multi-cycle unit; must satisfy MC_STAGE <= NSTAGES-2.
MC_TIMEOUT, 64, maximum MC_WAIT cycles; 0 disables the timeout.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  clock; one clock domain.
rst  in  1  reset, synchronous, active-high.
load_use_hazard  in  1  from hazard unit; load-use hazard in HAZ_STAGE.
redirect_valid  in  1  branch, jal or jalr taken in RESOLVE_STAGE.
mc_start  in  1  single-cycle pulse; multi-cycle op issued in MC_STAGE.
mc_done  in  1  multi-cycle result valid.
mem_wait  in  1  data memory not ready.
cnt_clr  in  1  synchronous clear of both counters.
pc_write  out  1  PC update enable.
preg_write  out  NSTAGES-1  per-register write enable.
preg_flush  out  NSTAGES-1  per-register bubble insert; overrides write.
mc_busy  out  1  FSM is in MC_WAIT.
mc_timeout  out  1  sticky error flag.
stall_cnt  out  CNT_W  cycles with pc_write=0.
flush_cnt  out  CNT_W  cycles in which a redirect flush was applied.

Behaviour:
- FSM states: RUN and MC_WAIT; both reset to RUN.
- Control outputs are combinational from state and inputs, so they act in the same cycle as the event.
- While rst=1:
  - pc_write=0, preg_write all 0, preg_flush all 1.
  - mc_busy=0, mc_timeout=0, counters 0, timer 0.
- Default (no event): pc_write=1, preg_write all 1, preg_flush all 0.
- Priority, highest first: mem_wait > MC stall > redirect > load_use.
- mem_wait=1:
  - pc_write=0, preg_write all 0, no flushes.
  - The FSM still advances: mc_done is accepted and the timer still counts.
- MC stall applies when state=MC_WAIT and mc_done=0, or when state=RUN with mc_start=1 and mc_done=0:
  - pc_write=0.
  - preg_write[k]=0 for k<MC_STAGE.
  - preg_flush[MC_STAGE]=1.
  - Registers above MC_STAGE run normally.
- A 1-cycle op (mc_start and mc_done in the same cycle) causes no stall; the FSM stays in RUN.
- redirect_valid, not masked by a higher-priority event:
  - preg_flush[k]=1 for all k<RESOLVE_STAGE.
  - pc_write=1.
  - flush_cnt increments.
- Redirect beats load_use: the instruction in HAZ_STAGE is wrong-path. This is a deliberate change from the prior controller, where stall won.
- redirect_valid is ignored in MC_WAIT.
- load_use_hazard alone:
  - pc_write=0.
  - preg_write[k]=0 for k<HAZ_STAGE.
  - preg_flush[HAZ_STAGE]=1.
- FSM transitions:
  - RUN -> MC_WAIT on mc_start & !mc_done; timer loads 1.
  - MC_WAIT -> RUN on mc_done.
  - Otherwise the timer increments.
  - If MC_TIMEOUT!=0, timer==MC_TIMEOUT and !mc_done, the FSM goes to RUN and sets mc_timeout. It stays set until rst.
- mc_start while in MC_WAIT is ignored.
- stall_cnt increments each non-reset cycle with pc_write=0.
- Both counters saturate at all-ones and never wrap.
- cnt_clr zeroes both counters and beats an increment in the same cycle.
- mc_busy=1 exactly when state=MC_WAIT.
- Reset mid-MC_WAIT returns the FSM to RUN on the next edge; a late mc_done after reset is ignored.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - state encoding ST_RUN=0, ST_MC_WAIT=1;
  - stage index constants STG_IF=0, STG_ID=1, STG_EX=2, STG_MEM=3, STG_WB=4.
- One sub-module, sat_counter, parametrised by width, with clr and inc inputs. It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
All scenarios use default parameters.
1. Reset: hold rst 3 cycles with all inputs 1 -> pc_write=0, preg_write=0000, preg_flush=1111, counters 0. After release with inputs 0 -> pc_write=1, preg_write=1111, preg_flush=0000.
2. Load-use only, 1 cycle -> pc_write=0, preg_write=1110, preg_flush=0010, stall_cnt=1.
3. load_use_hazard and redirect_valid together -> preg_flush=0011, pc_write=1, flush_cnt=1, stall_cnt unchanged.
4. mc_start with mc_done 4 cycles later:
   - 4 cycles with mc_busy=1 and preg_write[1:0]=00, preg_flush[2]=1, preg_write[3]=1;
   - pc_write=0 for those 4 stall cycles plus the start cycle, so stall_cnt=5;
   - redirect_valid pulsed mid-wait produces no flush.
5. mc_start with mc_done never asserted -> after 64 MC_WAIT cycles the FSM is back in RUN, mc_timeout=1 and stays 1; a later rst clears it.
6. Force stall_cnt to 0xFFFE with 3 further stall cycles -> it holds at 0xFFFF. Then cnt_clr together with a stall -> 0.
